// File: rtl/btn_scan_pkg.sv
// Shared types for the multiplexed button scanner: event codes, the queued
// event record and the scan scheduler state.
package btn_scan_pkg;

   // Widest channel index supported (16 channels)
   localparam int CH_MAX_W = 4;
   // Debounce run counter width (STABLE_TICKS up to 255)
   localparam int CNT_W = 8;

   typedef enum logic [1:0] {
      EVT_PRESS   = 2'b00,
      EVT_RELEASE = 2'b01,
      EVT_LONG    = 2'b10
   } evt_code_e;

   typedef struct packed {
      logic [CH_MAX_W-1:0] ch;
      evt_code_e           code;
   } evt_t;

   typedef enum logic {
      SCAN_IDLE   = 1'b0,
      SCAN_ACTIVE = 1'b1
   } scan_state_e;

endpackage

// File: rtl/btn_evt_fifo.sv
// Small synchronous event FIFO. A push into a full FIFO is accepted when a pop
// happens in the same cycle; otherwise the caller sees full_o and drops it.
module btn_evt_fifo #(
   parameter int W     = 6,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic [W-1:0] wdata_i,
   input  logic         pop_i,
   output logic [W-1:0] rdata_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   logic          push_ok;
   logic          pop_ok;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign pop_ok  = pop_i & ~empty_o;
   assign push_ok = push_i & (~full_o | pop_ok);
   assign rdata_o = mem_q[rd_ptr_q];

   // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is 2^AW)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (pop_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/button_scan_ctrl.sv
// Multi-channel push-button front end. One debounce/hold engine is shared by
// all channels: on every prescaler tick the scheduler visits channel
// 0..N_CH-1, one per clock, and queues press/release(/long) events.
// Optional feature macro: BTN_SCAN_LONG_PRESS_EN enables hold counters and
// long-press events; without it LONG_TICKS only takes part in range checks.
module button_scan_ctrl
   import btn_scan_pkg::*;
#(
   parameter int N_CH         = 4,
   parameter int TICK_DIV     = 1000,
   parameter int STABLE_TICKS = 16,
   parameter int LONG_TICKS   = 500,
   parameter int FIFO_DEPTH   = 4,
   localparam int CH_W        = $clog2(N_CH)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] btn_raw,
   output logic [N_CH-1:0] stable,
   output logic            evt_valid,
   input  logic            evt_ready,
   output logic [CH_W-1:0] evt_ch,
   output logic [1:0]      evt_code,
   output logic            overflow,
   input  logic            clr_overflow
);

   localparam int PRE_W = $clog2(TICK_DIV);

   // A tick must never land inside a scan, and counters must fit their widths
   if (TICK_DIV <= N_CH + 1 || STABLE_TICKS < 1 || STABLE_TICKS > 255 ||
       LONG_TICKS < 1 || LONG_TICKS > 65535 || N_CH < 2 || N_CH > 16) begin : g_param_check
      $error("button_scan_ctrl: parameter out of range");
   end

   logic [N_CH-1:0]  sync1_q;
   logic [N_CH-1:0]  sync2_q;
   logic [PRE_W-1:0] pre_q;
   logic             tick;
   scan_state_e      state_q;
   logic [CH_W-1:0]  ch_q;
   logic [N_CH-1:0]  stable_q;
   logic [CNT_W-1:0] cnt_q [N_CH];
   logic             overflow_q;

   logic             visit;
   logic             s_cur;
   logic             lvl_cur;
   logic             lvl_d;
   logic [CNT_W-1:0] cnt_d;
   logic             evt_hit;
   evt_code_e        push_code;
   logic             push;
   evt_t             push_evt;
   evt_t             head;
   logic [$bits(evt_t)-1:0] fifo_rdata;
   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_pop;
   logic             drop;

`ifdef BTN_SCAN_LONG_PRESS_EN
   localparam int HOLD_W = 16;
   logic [HOLD_W-1:0] hold_q [N_CH];
   logic [HOLD_W-1:0] hold_d;
`endif

   // Two-flop synchronizer for the asynchronous button pins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
      end
   end

   // Sample-rate prescaler: 0..TICK_DIV-1, tick during the last count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q <= '0;
      end else if (pre_q == PRE_W'(TICK_DIV - 1)) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_q + PRE_W'(1);
      end
   end

   assign tick = (pre_q == PRE_W'(TICK_DIV - 1));

   // Scan scheduler: wait for a tick, then walk every channel once, one per clock
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SCAN_IDLE;
         ch_q    <= '0;
      end else begin
         case (state_q)
            SCAN_IDLE: begin
               if (tick) begin
                  state_q <= SCAN_ACTIVE;
                  ch_q    <= '0;
               end
            end
            SCAN_ACTIVE: begin
               if (ch_q == CH_W'(N_CH - 1)) begin
                  state_q <= SCAN_IDLE;
                  ch_q    <= '0;
               end else begin
                  ch_q <= ch_q + CH_W'(1);
               end
            end
            default: begin
               state_q <= SCAN_IDLE;
               ch_q    <= '0;
            end
         endcase
      end
   end

   assign visit   = (state_q == SCAN_ACTIVE);
   assign s_cur   = sync2_q[ch_q];
   assign lvl_cur = stable_q[ch_q];

   // Shared evaluation engine for the channel being visited this clock
   always_comb begin
      lvl_d     = lvl_cur;
      cnt_d     = cnt_q[ch_q];
      evt_hit   = 1'b0;
      push_code = EVT_PRESS;
      if (s_cur == lvl_cur) begin
         cnt_d = '0;
      end else if (cnt_q[ch_q] == CNT_W'(STABLE_TICKS - 1)) begin
         lvl_d     = s_cur;
         cnt_d     = '0;
         evt_hit   = 1'b1;
         push_code = s_cur ? EVT_PRESS : EVT_RELEASE;
      end else begin
         cnt_d = cnt_q[ch_q] + CNT_W'(1);
      end
`ifdef BTN_SCAN_LONG_PRESS_EN
      // Hold count only runs while the level stays high; saturation makes the
      // long-press event fire once per press. A flip can never coincide with it.
      hold_d = hold_q[ch_q];
      if (!lvl_cur || (lvl_d != lvl_cur)) begin
         hold_d = '0;
      end else if (hold_q[ch_q] != HOLD_W'(LONG_TICKS)) begin
         hold_d = hold_q[ch_q] + HOLD_W'(1);
         if (hold_d == HOLD_W'(LONG_TICKS)) begin
            evt_hit   = 1'b1;
            push_code = EVT_LONG;
         end
      end
`endif
   end

   // Commit the visited channel's level and counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stable_q <= '0;
         for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
`ifdef BTN_SCAN_LONG_PRESS_EN
         for (int i = 0; i < N_CH; i++) hold_q[i] <= '0;
`endif
      end else if (visit) begin
         stable_q[ch_q] <= lvl_d;
         cnt_q[ch_q]    <= cnt_d;
`ifdef BTN_SCAN_LONG_PRESS_EN
         hold_q[ch_q]   <= hold_d;
`endif
      end
   end

   assign push          = visit & evt_hit;
   assign push_evt.ch   = CH_MAX_W'(ch_q);
   assign push_evt.code = push_code;
   assign fifo_pop      = evt_valid & evt_ready;
   assign drop          = push & fifo_full & ~fifo_pop;

   btn_evt_fifo #(
      .W     ($bits(evt_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .wdata_i (push_evt),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Sticky overflow flag; a drop in the same cycle beats the clear request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q <= 1'b0;
      end else if (drop) begin
         overflow_q <= 1'b1;
      end else if (clr_overflow) begin
         overflow_q <= 1'b0;
      end
   end

   assign head      = evt_t'(fifo_rdata);
   assign stable    = stable_q;
   assign evt_valid = ~fifo_empty;
   assign evt_ch    = CH_W'(head.ch);
   assign evt_code  = head.code;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_button_scan_ctrl.sv
// Bench for button_scan_ctrl (N_CH=4, TICK_DIV=8, STABLE_TICKS=3, LONG_TICKS=5,
// FIFO_DEPTH=4). A sample-history model predicts levels and the event queue
// every cycle; directed scenarios add literal expectations on top.
module tb_button_scan_ctrl;

   localparam int N_CH  = 4;
   localparam int TD    = 8;
   localparam int ST    = 3;
   localparam int LT    = 5;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] btn_raw = 4'b0;
   logic [3:0] stable;
   logic       evt_valid;
   logic       evt_ready = 1'b0;
   logic [1:0] evt_ch;
   logic [1:0] evt_code;
   logic       overflow;
   logic       clr_overflow = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   button_scan_ctrl #(
      .N_CH(N_CH), .TICK_DIV(TD), .STABLE_TICKS(ST), .LONG_TICKS(LT), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .stable(stable),
      .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ch(evt_ch),
      .evt_code(evt_code), .overflow(overflow), .clr_overflow(clr_overflow)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   int        k;                   // clock cycles since reset release
   bit [3:0]  m_d1, m_d2;          // raw pins delayed by one and two clocks
   bit [3:0]  m_lvl;
   bit        m_hist [N_CH][ST];   // previous samples per channel, [0] newest
   int        m_hold [N_CH];
   int        m_q[$];              // queued events: ch*4 + code
   bit        m_ovf;
   bit        hit_full_pop;
   bit        man_ready = 1'b0;
   bit        armed = 1'b0;

   // Event (if any) produced by the visit happening in the current cycle.
   // Channel c is sampled in every cycle k >= TD with k mod TD == c.
   function automatic void predict(output bit pushes, output int ev);
      int c;
      bit s;
      bit flip;
      pushes = 1'b0;
      ev = 0;
      if (k < TD || (k % TD) >= N_CH) return;
      c = k % TD;
      s = m_d2[c];
      flip = (s != m_lvl[c]);
      for (int j = 0; j < ST - 1; j++) if (m_hist[c][j] == m_lvl[c]) flip = 1'b0;
      if (flip) begin
         pushes = 1'b1;
         ev = c * 4 + (s ? 0 : 1);
      end
`ifdef BTN_SCAN_LONG_PRESS_EN
      else if (m_lvl[c] && (m_hold[c] + 1 == LT)) begin
         pushes = 1'b1;
         ev = c * 4 + 2;
      end
`endif
   endfunction

   always @(posedge clk or negedge rst_n) begin : model
      bit pushes;
      int ev;
      int c;
      bit pop;
      bit full_before;
      if (!rst_n) begin
         k = 0; m_d1 = '0; m_d2 = '0; m_lvl = '0; m_ovf = 1'b0;
         for (int i = 0; i < N_CH; i++) begin
            m_hold[i] = 0;
            for (int j = 0; j < ST; j++) m_hist[i][j] = 1'b0;
         end
         m_q.delete();
      end else begin
         predict(pushes, ev);
         if (k >= TD && (k % TD) < N_CH) begin
            c = k % TD;
            if (pushes && (ev % 4) != 2) begin
               m_lvl[c] = ~m_lvl[c];
               m_hold[c] = 0;
            end else if (!m_lvl[c]) begin
               m_hold[c] = 0;
            end else if (m_hold[c] < LT) begin
               m_hold[c]++;
            end
            for (int j = ST - 1; j > 0; j--) m_hist[c][j] = m_hist[c][j-1];
            m_hist[c][0] = m_d2[c];
         end
         full_before = (m_q.size() == DEPTH);
         pop = (m_q.size() > 0) && evt_ready;
         if (pop) void'(m_q.pop_front());
         if (pushes) begin
            if (full_before && pop) hit_full_pop = 1'b1;
            if (m_q.size() < DEPTH) m_q.push_back(ev);
            else m_ovf = 1'b1;
         end
         if (!(pushes && m_q.size() >= DEPTH && full_before && !pop) && clr_overflow) m_ovf = 1'b0;
         m_d2 = m_d1;
         m_d1 = btn_raw;
         k++;
      end
   end

   // Ready: manual pops, or (when armed) exactly the cycle a push meets a full queue
   always @(negedge clk) begin : rdy
      bit p;
      int e;
      #1;
      predict(p, e);
      evt_ready = man_ready | (armed & p & (m_q.size() == DEPTH));
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (rst_n) begin
         chk("stable", stable, m_lvl);
         chk("evt_valid", evt_valid, m_q.size() > 0);
         chk("overflow", overflow, m_ovf);
         if (m_q.size() > 0) begin
            chk("evt_ch", evt_ch, m_q[0] / 4);
            chk("evt_code", evt_code, m_q[0] % 4);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_ticks(input int n);
      repeat (n * TD) @(negedge clk);
   endtask

   task automatic pop_expect(input string nm, input int ch, input int code);
      int t = 0;
      while (!evt_valid && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (!evt_valid) begin
         chk({nm, "_timeout"}, 0, 1);
         return;
      end
      chk({nm, "_ch"}, evt_ch, ch);
      chk({nm, "_code"}, evt_code, code);
      man_ready = 1'b1;
      @(negedge clk);
      man_ready = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while (evt_valid && t < 20) begin
         man_ready = 1'b1;
         @(negedge clk);
         t++;
      end
      man_ready = 1'b0;
      @(negedge clk);
      chk("drained", evt_valid, 0);
   endtask

   task automatic clear_ovf();
      clr_overflow = 1'b1;
      @(negedge clk);
      clr_overflow = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int t;
      // Reset values
      #12;
      chk("rst_stable", stable, 0);
      chk("rst_valid", evt_valid, 0);
      chk("rst_ch", evt_ch, 0);
      chk("rst_code", evt_code, 0);
      chk("rst_ovf", overflow, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Press and release on channel 2
      btn_raw = 4'b0100;
      pop_expect("press2", 2, 0);
      chk("stable_press2", stable, 4'b0100);
      btn_raw = 4'b0000;
      pop_expect("release2", 2, 1);
      chk("stable_release2", stable, 4'b0000);

      // Two-sample glitch on channel 1 must be filtered
      btn_raw = 4'b0010;
      repeat (2 * TD) @(negedge clk);
      btn_raw = 4'b0000;
      wait_ticks(5);
      chk("glitch_stable", stable, 0);
      chk("glitch_valid", evt_valid, 0);

      // Ten-tick hold on channel 0
      btn_raw = 4'b0001;
      wait_ticks(10);
      btn_raw = 4'b0000;
      wait_ticks(6);
      pop_expect("hold_press", 0, 0);
`ifdef BTN_SCAN_LONG_PRESS_EN
      pop_expect("hold_long", 0, 2);
`endif
      pop_expect("hold_release", 0, 1);
      chk("hold_ovf", overflow, 0);

      // Overflow: everything beyond four queued events is dropped
      btn_raw = 4'b1111;
      wait_ticks(12);
      btn_raw = 4'b0000;
      wait_ticks(6);
      chk("ovf_set", overflow, 1);
      chk("ovf_valid", evt_valid, 1);
      clear_ovf();
      chk("ovf_cleared", overflow, 0);
      pop_expect("ovf_q0", 0, 0);
      pop_expect("ovf_q1", 1, 0);
      pop_expect("ovf_q2", 2, 0);
      pop_expect("ovf_q3", 3, 0);
      chk("ovf_empty", evt_valid, 0);

      // Full queue with a pop in the push cycle: nothing lost
      btn_raw = 4'b1111;
      wait_ticks(5);
      chk("full_valid", evt_valid, 1);
      hit_full_pop = 1'b0;
      armed = 1'b1;
      btn_raw = 4'b0000;
      t = 0;
      while (!hit_full_pop && t < 200) begin
         @(negedge clk);
         t++;
      end
      armed = 1'b0;
      chk("fullpop_seen", hit_full_pop, 1);
      chk("fullpop_ovf", overflow, 0);
      chk("fullpop_head_ch", evt_ch, 1);
      chk("fullpop_head_code", evt_code, 0);
      wait_ticks(6);
      clear_ovf();
      drain();

      // Reset in the middle of a scan with two events queued
      btn_raw = 4'b0011;
      wait_ticks(5);
      chk("pre_rst_stable", stable, 4'b0011);
      chk("pre_rst_valid", evt_valid, 1);
      t = 0;
      while ((k % TD) != 1 && t < 20) begin
         @(negedge clk);
         t++;
      end
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_stable", stable, 0);
      chk("midrst_valid", evt_valid, 0);
      chk("midrst_ch", evt_ch, 0);
      chk("midrst_code", evt_code, 0);
      chk("midrst_ovf", overflow, 0);
      btn_raw = 4'b0000;
      @(negedge clk);
      rst_n = 1'b1;
      wait_ticks(6);
      chk("post_rst_valid", evt_valid, 0);
      chk("post_rst_stable", stable, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
